div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing and operand/result conditioning stage that sits directly upstream of the iterative unsigned divider core in the RV64 execute unit. It accepts M-extension divide/remainder requests (DIV, DIVU, REM, REMU and their W forms) over a valid/ready handshake. It converts operands to unsigned magnitudes, launches the core, and waits for completion. It then applies RISC-V sign and word-extension rules and holds the result until writeback accepts it. Divide-by-zero and signed overflow are resolved locally without starting the core.

## Interface
- XLEN, 64, datapath width; only 64 is supported.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_word  in  1  W variant; use src[31:0] only.
- req_src1  in  64  dividend.
- req_src2  in  64  divisor.
- req_rd  in  5  destination tag, returned unchanged.
- flush  in  1  pipeline kill; discards the current operation.
- core_start  out  1  one-cycle launch pulse to the divider core.
- core_dividend  out  64  unsigned dividend magnitude, stable from start until done.
- core_divisor  out  64  unsigned divisor magnitude, stable from start until done.
- core_quot  in  64  unsigned quotient, valid with core_done.
- core_rem  in  64  unsigned remainder, valid with core_done.
- core_done  in  1  core result valid (single-cycle pulse).
- rsp_valid  out  1  result present.
- rsp_ready  in  1  writeback accepts the result.
- rsp_data  out  64  final rd value.
- rsp_rd  out  5  tag of the result.

## Operation
- FSM states: IDLE, BUSY, DRAIN, RESP. Reset state is IDLE.
- req_ready = 1 in IDLE with rst high, else 0. A request is accepted when req_valid & req_ready & !flush.
- Operand prep on accept:
  - W form: a = src1[31:0], b = src2[31:0], each sign-extended (signed op) or zero-extended (unsigned op) to 64 bits.
  - Signed op: magnitudes are |a|, |b|. Record neg_q = a[63]^b[63] and neg_r = a[63].
  - Unsigned op: magnitudes are a and b; neg_q = neg_r = 0.
  - Magnitudes, op, word flag, signs and tag are all registered.
- Special cases, decided at accept; the core is not started and the FSM goes IDLE→RESP:
  - b == 0: quotient = all ones; remainder = a.
  - Signed op with a == most negative value (64-bit, or 32-bit after extension for W) and b == -1: quotient = a; remainder = 0.
- Normal path: IDLE→BUSY.
  - core_start is high exactly in the first BUSY cycle.
  - core_done is ignored in that cycle.
  - On core_done: q = neg_q ? -core_quot : core_quot; r = neg_r ? -core_rem : core_rem. Select q for DIV*, r for REM*.
  - W form: rsp_data = sign-extension of bit 31 of the selected value, for signed and unsigned W ops alike.
  - Result is registered; FSM goes BUSY→RESP.
- RESP: rsp_valid = 1. rsp_data and rsp_rd are held stable until rsp_ready, then RESP→IDLE.
- Flush rules:
  - In RESP: go to IDLE; response dropped.
  - In BUSY: go to DRAIN, unless core_done is high in the same cycle, in which case go to IDLE and discard the result.
  - DRAIN: req_ready = 0, rsp_valid = 0. Wait for core_done, discard it, then go to IDLE.
  - In IDLE: a simultaneous req_valid is not accepted.
- Flush has priority over rsp_ready and core_done.

## Timing
- Reset values: req_ready 1 after release (0 while rst low); core_start 0; core_dividend 0; core_divisor 0; rsp_valid 0; rsp_data 0; rsp_rd 0.
- Accept at edge T0. Normal path: core_start is high in cycle T0+1. If core_done is high in cycle Td, rsp_valid is high from Td+1.
- Special-case path: rsp_valid is high in T0+1 (one-cycle latency).
- Response handshake completes at edge Tr. req_ready is high in Tr+1. No same-cycle accept while in RESP.
- Throughput: one operation in flight. Maximum rate is one result per (core latency + 3) cycles.

## Test plan
- DIV src1=-7, src2=2 → rsp_data 0xFFFFFFFFFFFFFFFD. REM with the same operands → 0xFFFFFFFFFFFFFFFF. core_start pulses once for each.
- DIVU src1=0x1234, src2=0 → 0xFFFFFFFFFFFFFFFF one cycle after accept, core_start never asserted. REMU with the same operands → 0x1234.
- DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → 0x8000000000000000. REM with the same operands → 0. Core not started.
- W forms:
  - DIVW src1=0x12345678_80000000, src2=0xABCDEF01_FFFFFFFF → 0xFFFFFFFF80000000 (overflow case).
  - DIVUW src1=0xABCD0000_FFFFFFFE, src2=2 → 0x000000007FFFFFFF.
  - REMW src1=-7 (low 32 bits), src2=3 → 0xFFFFFFFFFFFFFFFF.
- Flush 2 cycles after core_start → DRAIN, req_ready held 0 until core_done, no rsp_valid, IDLE the following cycle. A new request then completes correctly.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_rd stable. Assert flush together with rsp_ready → no response counted, IDLE next cycle.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing and sign/word conditioning around an iterative
// unsigned divider core. Handles RISC-V DIV/DIVU/REM/REMU (+W forms),
// resolves divide-by-zero and signed overflow locally, and holds the
// final rd value until writeback takes it.
module div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            core_start,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  input  logic [XLEN-1:0] core_quot,
  input  logic [XLEN-1:0] core_rem,
  input  logic            core_done,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t state, state_nxt;

  // two's-complement negate when the recorded sign says so
  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // W results are always the sign-extension of the low word
  function automatic logic [XLEN-1:0] word_ext(input logic word, input logic [XLEN-1:0] v);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic            is_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_min;
  logic            a_neg, b_neg;
  logic            div_zero, sovf, special;
  logic [XLEN-1:0] special_res;
  logic            accept, first_busy, done_eff;
  logic            neg_q, neg_r, is_rem, is_word;
  logic [XLEN-1:0] core_res;

  // Operand conditioning for the request currently presented
  assign is_signed = ~req_op[0];
  assign a_ext = req_word ? {{(XLEN-32){is_signed & req_src1[31]}}, req_src1[31:0]} : req_src1;
  assign b_ext = req_word ? {{(XLEN-32){is_signed & req_src2[31]}}, req_src2[31:0]} : req_src2;
  assign a_neg = is_signed & a_ext[XLEN-1];
  assign b_neg = is_signed & b_ext[XLEN-1];
  // most negative value after extension (64-bit or sign-extended 32-bit)
  assign a_min = req_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign sovf     = is_signed & (a_ext == a_min) & (b_ext == '1);
  assign special  = div_zero | sovf;
  // div-by-zero: q = all ones, r = a; overflow: q = a, r = 0
  assign special_res = word_ext(req_word,
                                req_op[1] ? (div_zero ? a_ext : '0)
                                          : (div_zero ? '1    : a_ext));

  // Result conditioning of the unsigned core outputs
  assign core_res = word_ext(is_word, is_rem ? cond_neg(neg_r, core_rem)
                                             : cond_neg(neg_q, core_quot));

  assign req_ready  = (state == IDLE) & rst;
  assign accept     = req_valid & req_ready & ~flush;
  assign core_start = (state == BUSY) & first_busy;
  // the core cannot legitimately finish in its launch cycle
  assign done_eff   = core_done & ~first_busy;
  assign rsp_valid  = (state == RESP);

  // State register and launch-cycle marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      first_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_busy <= accept & ~special;
    end
  end

  // Next-state logic; flush outranks rsp_ready and core_done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = special ? RESP : BUSY;
      BUSY:  begin
        if (flush)         state_nxt = done_eff ? IDLE : DRAIN;
        else if (done_eff) state_nxt = RESP;
      end
      DRAIN: if (core_done) state_nxt = IDLE;
      RESP:  if (flush || rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/context capture at accept and result capture on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_dividend <= '0;
      core_divisor  <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      is_rem        <= 1'b0;
      is_word       <= 1'b0;
      rsp_rd        <= '0;
      rsp_data      <= '0;
    end else if (accept) begin
      core_dividend <= cond_neg(a_neg, a_ext);
      core_divisor  <= cond_neg(b_neg, b_ext);
      neg_q         <= a_neg ^ b_neg;
      neg_r         <= a_neg;
      is_rem        <= req_op[1];
      is_word       <= req_word;
      rsp_rd        <= req_rd;
      if (special) rsp_data <= special_res;
    end else if ((state == BUSY) && done_eff && !flush) begin
      rsp_data <= core_res;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized bench for div_ctrl with a
// behavioural divider-core model and a RISC-V level result model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_word;
  logic [63:0] req_src1, req_src2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        core_start;
  logic [63:0] core_dividend, core_divisor, core_quot, core_rem;
  logic        core_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_rd;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int core_lat = 3;
  logic [63:0] dd_l, dv_l;

  div_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_src1(req_src1), .req_src2(req_src2),
    .req_rd(req_rd), .flush(flush),
    .core_start(core_start), .core_dividend(core_dividend),
    .core_divisor(core_divisor), .core_quot(core_quot), .core_rem(core_rem),
    .core_done(core_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd)
  );

  always #5 clk = ~clk;

  // count cycles in which the launch pulse is high
  always @(posedge clk) if (core_start === 1'b1) start_cnt <= start_cnt + 1;

  // behavioural divider core: answers core_lat cycles after launch
  initial begin : core_model
    core_done = 1'b0; core_quot = '0; core_rem = '0;
    forever begin
      @(posedge clk); #1;
      if (core_start === 1'b1) begin
        dd_l = core_dividend; dv_l = core_divisor;
        repeat (core_lat) begin @(posedge clk); #1; end
        n_vec++;
        if (core_dividend !== dd_l || core_divisor !== dv_l) begin
          n_err++;
          $display("FAIL core_operands_stable: got %h/%h want %h/%h",
                   core_dividend, core_divisor, dd_l, dv_l);
        end
        core_quot = (dv_l == 0) ? '1 : dd_l / dv_l;
        core_rem  = (dv_l == 0) ? dd_l : dd_l % dv_l;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
  end

  // RISC-V M-extension result, computed with plain signed/unsigned arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic word,
                                            input logic [63:0] s1, input logic [63:0] s2);
    longint sa, sb;
    longint unsigned ua, ub;
    int wa, wb;
    int unsigned uwa, uwb;
    logic [31:0] w;
    logic [63:0] r;
    sa = s1; sb = s2; ua = s1; ub = s2;
    wa = s1[31:0]; wb = s2[31:0]; uwa = s1[31:0]; uwb = s2[31:0];
    w = '0; r = '0;
    if (word) begin
      case (op)
        2'b00: if (wb == 0) w = '1; else if (wa == 32'h8000_0000 && wb == -1) w = wa; else w = wa / wb;
        2'b01: if (uwb == 0) w = '1; else w = uwa / uwb;
        2'b10: if (wb == 0) w = wa; else if (wa == 32'h8000_0000 && wb == -1) w = '0; else w = wa % wb;
        default: if (uwb == 0) w = uwa; else w = uwa % uwb;
      endcase
      r = {{32{w[31]}}, w};
    end else begin
      case (op)
        2'b00: if (sb == 0) r = '1; else if (sa == 64'h8000_0000_0000_0000 && sb == -1) r = sa; else r = sa / sb;
        2'b01: if (ub == 0) r = '1; else r = ua / ub;
        2'b10: if (sb == 0) r = sa; else if (sa == 64'h8000_0000_0000_0000 && sb == -1) r = '0; else r = sa % sb;
        default: if (ub == 0) r = ua; else r = ua % ub;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic word,
                                      input logic [63:0] s1, input logic [63:0] s2);
    logic sgn;
    sgn = ~op[0];
    if (word) return (s2[31:0] == 0) || (sgn && s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF);
    return (s2 == 0) || (sgn && s1 == 64'h8000_0000_0000_0000 && s2 == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // present one request for one cycle; returns at #1 after the accept edge
  task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [4:0] rd);
    req_op = op; req_word = word; req_src1 = s1; req_src2 = s2; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // full transaction with latency, result, tag and launch-count checks
  task automatic do_op(input logic [1:0] op, input logic word, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [4:0] rd, input logic [63:0] exp,
                       input logic spec, input string name);
    int s0, cyc;
    s0 = start_cnt;
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s ready_idle: got %b want 1", name, req_ready); end
    issue(op, word, s1, s2, rd);
    n_vec++;
    if (spec) begin
      if (rsp_valid !== 1'b1 || core_start !== 1'b0) begin
        n_err++; $display("FAIL %s special_latency: rsp_valid %b core_start %b want 1/0", name, rsp_valid, core_start);
      end
    end else if (core_start !== 1'b1) begin
      n_err++; $display("FAIL %s start_after_accept: got %b want 1", name, core_start);
    end
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL %s rsp_timeout: rsp_valid %b after %0d cycles want 1", name, rsp_valid, cyc);
    end else if (rsp_data !== exp || rsp_rd !== rd) begin
      n_err++; $display("FAIL %s result: got %h rd %0d want %h rd %0d", name, rsp_data, rsp_rd, exp, rd);
    end
    n_vec++;
    if (start_cnt - s0 !== (spec ? 0 : 1)) begin
      n_err++; $display("FAIL %s start_count: got %0d want %0d", name, start_cnt - s0, spec ? 0 : 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s after_handshake: valid %b ready %b want 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_word = 1'b0; req_src1 = '0;
    req_src2 = '0; req_rd = '0; flush = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b0 || core_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 64'h0 ||
        rsp_rd !== 5'h0 || core_dividend !== 64'h0 || core_divisor !== 64'h0) begin
      n_err++;
      $display("FAIL reset_values: ready %b start %b valid %b data %h rd %0d dvd %h dvs %h want all 0",
               req_ready, core_start, rsp_valid, rsp_data, rsp_rd, core_dividend, core_divisor);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    core_lat = 3;
    do_op(2'b00, 1'b0, -64'sd7, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_neg7_2");
    do_op(2'b10, 1'b0, -64'sd7, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "rem_neg7_2");
    do_op(2'b01, 1'b0, 64'h1234, 64'h0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "divu_by0");
    do_op(2'b11, 1'b0, 64'h1234, 64'h0, 5'd4, 64'h1234, 1'b1, "remu_by0");
    do_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5,
          64'h8000_0000_0000_0000, 1'b1, "div_ovf");
    do_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'h0, 1'b1, "rem_ovf");
    do_op(2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_EF01_FFFF_FFFF, 5'd7,
          64'hFFFF_FFFF_8000_0000, 1'b1, "divw_ovf");
    do_op(2'b01, 1'b1, 64'hABCD_0000_FFFF_FFFE, 64'd2, 5'd8, 64'h0000_0000_7FFF_FFFF, 1'b0, "divuw");
    do_op(2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "remw");
  endtask

  task automatic test_random();
    logic [1:0] op; logic word; logic [63:0] s1, s2; longint t; int cls;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 9);
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      if (cls == 0) s2 = word ? {$urandom, 32'h0} : 64'h0;
      else if (cls == 1) begin
        s1 = word ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        s2 = word ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (cls < 5) begin
        t = longint'($urandom_range(0, 400)) - 200; s1 = t;
        t = longint'($urandom_range(0, 40)) - 20;   s2 = t;
        if (s2 == 0) s2 = 64'd7;
      end
      core_lat = $urandom_range(1, 6);
      do_op(op, word, s1, s2, 5'($urandom_range(0, 31)), ref_model(op, word, s1, s2),
            is_special(op, word, s1, s2), "random");
    end
  endtask

  task automatic test_flush_busy();
    // flush two cycles after launch: drain until the core answers
    core_lat = 8;
    issue(2'b00, 1'b0, 64'd1000, 64'd7, 5'd10);
    n_vec++;
    if (core_start !== 1'b1) begin n_err++; $display("FAIL flush_busy_start: got %b want 1", core_start); end
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      n_vec++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL drain_cycle%0d: ready %b valid %b want 0/0", k, req_ready, rsp_valid);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_exit: ready %b valid %b want 1/0", req_ready, rsp_valid);
    end
    core_lat = 2;
    do_op(2'b01, 1'b0, 64'd1000, 64'd7, 5'd11, 64'd142, 1'b0, "after_drain");
    // flush in the same cycle the core finishes: straight back to IDLE
    core_lat = 4;
    issue(2'b11, 1'b0, 64'd1000, 64'd7, 5'd12);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_with_done: ready %b valid %b want 1/0", req_ready, rsp_valid);
    end
    do_op(2'b11, 1'b0, 64'd1000, 64'd7, 5'd13, 64'd6, 1'b0, "after_flush_done");
  endtask

  task automatic test_resp_hold();
    int cyc;
    core_lat = 2;
    issue(2'b00, 1'b0, 64'd100, -64'sd9, 5'd20);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    req_op = 2'b01; req_src1 = 64'd5; req_src2 = 64'd1; req_rd = 5'd30;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'hFFFF_FFFF_FFFF_FFF5 || rsp_rd !== 5'd20 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL resp_hold%0d: valid %b data %h rd %0d ready %b want 1 fffffffffffffff5 20 0",
                 k, rsp_valid, rsp_data, rsp_rd, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL resp_flush: valid %b ready %b want 0/1", rsp_valid, req_ready);
    end
    // flush in IDLE blocks a simultaneous request
    req_op = 2'b01; req_word = 1'b0; req_src1 = 64'd9; req_src2 = 64'd3; req_rd = 5'd21;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if (core_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_flush_block: start %b valid %b ready %b want 0/0/1", core_start, rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom}; b = {32'h0, $urandom} | 64'h1;
      core_lat = 1;
      do_op(2'(i % 4), 1'b0, a, b, 5'(i), ref_model(2'(i % 4), 1'b0, a, b), 1'b0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_flush_busy();
    test_resp_hold();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
